call_stack_param: RTL

- Parameterised hardware return-address stack for the PIC-style multi-cycle core.
- Used by CALL (push PC) and RETURN (pop to PC).
- Generalises the fixed stack to configurable depth and address width.
- Adds a selectable overflow policy (circular overwrite or reject), occupancy reporting, sticky error flags and a same-cycle replace-top operation.

---
 rtl/pic_core_pkg.sv | 13 +
 rtl/call_stack_param.sv | 95 +++++++++
 2 files changed

// File: rtl/pic_core_pkg.sv
// Shared definitions for the PIC-style multi-cycle core.
// Default PC width, return-stack depth and stack overflow policies.
package pic_core_pkg;

    localparam int PC_W = 11;
    localparam int STACK_DEPTH = 8;

    typedef enum logic {
        STK_REJECT = 1'b0,
        STK_WRAP   = 1'b1
    } stack_mode_e;

endpackage

// File: rtl/call_stack_param.sv
// Parameterised return-address stack used by CALL/RETURN.
// Circular register array with occupancy count and sticky error flags.
module call_stack_param
    import pic_core_pkg::*;
#(
    parameter int ADDR_W    = PC_W,
    parameter int DEPTH     = STACK_DEPTH,
    parameter int WRAP_MODE = int'(STK_WRAP)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            stack_in,
    input  logic                         clr_err,
    output logic [ADDR_W-1:0]            stack_out,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic WRAP = (WRAP_MODE != 0);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     top_ptr;
    logic [LW-1:0]     lvl;

    logic do_repl;
    logic do_push;
    logic do_pop;
    logic ovf_ev;
    logic unf_ev;
    logic mem_we;
    logic [PW-1:0] mem_wa;

    assign top_ptr   = wp - PW'(1);
    assign level     = lvl;
    assign empty     = (lvl == '0);
    assign full      = (lvl == LW'(DEPTH));
    assign stack_out = empty ? '0 : mem[top_ptr];

    // Push+pop on an empty stack degrades to a plain push.
    always_comb begin
        do_repl = push & pop & ~empty;
        do_push = push & ~do_repl;
        do_pop  = pop & ~push & ~empty;
        ovf_ev  = do_push & full;
        unf_ev  = pop & ~push & empty;
        mem_we  = 1'b0;
        mem_wa  = wp;
        if (do_repl) begin
            mem_we = 1'b1;
            mem_wa = top_ptr;
        end else if (do_push && (!full || WRAP)) begin
            mem_we = 1'b1;
            mem_wa = wp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            lvl       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push && !full) begin
                wp  <= wp + PW'(1);
                lvl <= lvl + LW'(1);
            end else if (do_push && full && WRAP) begin
                wp  <= wp + PW'(1);
            end else if (do_pop) begin
                wp  <= top_ptr;
                lvl <= lvl - LW'(1);
            end
            overflow  <= ovf_ev | (overflow & ~clr_err);
            underflow <= unf_ev | (underflow & ~clr_err);
        end
    end

    // Storage is deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            mem[mem_wa] <= stack_in;
    end

    a_excl: assert property (@(posedge clk) !(empty && full));
    a_range: assert property (@(posedge clk) lvl <= LW'(DEPTH));

endmodule
